// File: rtl/alu_op_issue.sv
// alu_op_issue
//   Decodes an RV32I instruction (opcode/funct3/funct7) into a 5-bit ALU
//   SELECT code. It holds that code stable until downstream consumes it, and
//   stretches the valid/ready handshake for multi-cycle MUL and DIV operations.
//
// Optional feature macro: RV32M_EN
//   Defined   : OP with funct7=0000001 decodes to MUL..REMU. These ops take
//               MUL_CYCLES or DIV_CYCLES cycles.
//   Undefined : those encodings are illegal, EXEC is never entered, and
//               o_busy is tied low.
//
// Ports
//   i_clk        clock; all state changes on its rising edge
//   i_reset      synchronous active-high reset
//   i_opcode     instruction bits [6:0]
//   i_funct3     instruction bits [14:12]
//   i_funct7     instruction bits [31:25]
//   i_in_valid   upstream presents an instruction
//   o_in_ready   instruction is accepted this cycle when i_in_valid is high
//   o_select     registered ALU select code
//   o_out_valid  o_select is final and the ALU result may be consumed
//   i_out_ready  downstream consumes the result this cycle
//   o_busy       multi-cycle operation in progress
//   o_illegal    accepted instruction did not decode (qualified by o_out_valid)
module alu_op_issue #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic [4:0] o_select,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_busy,
  output logic       o_illegal
);

  localparam logic [4:0] SEL_ADD  = 5'b00000;
  localparam logic [4:0] SEL_SUB  = 5'b00001;
  localparam logic [4:0] SEL_AND  = 5'b00010;
  localparam logic [4:0] SEL_OR   = 5'b00011;
  localparam logic [4:0] SEL_XOR  = 5'b00100;
  localparam logic [4:0] SEL_SLL  = 5'b00101;
  localparam logic [4:0] SEL_SRL  = 5'b00110;
  localparam logic [4:0] SEL_SRA  = 5'b00111;
  localparam logic [4:0] SEL_SLT  = 5'b01000;
  localparam logic [4:0] SEL_SLTU = 5'b01001;
  localparam logic [4:0] SEL_FWD  = 5'b01010;
  localparam logic [4:0] SEL_NOP  = 5'b11111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] CLS_SINGLE = 2'd0;
  localparam logic [1:0] CLS_MUL    = 2'd1;
  localparam logic [1:0] CLS_DIV    = 2'd2;

  // Counter preload: EXEC lasts L-1 cycles, and the last EXEC cycle sees count 0.
  localparam logic [3:0] MUL_LOAD = (MUL_CYCLES > 32'd1) ? 4'(MUL_CYCLES - 32'd2) : 4'd0;
  localparam logic [3:0] DIV_LOAD = (DIV_CYCLES > 32'd1) ? 4'(DIV_CYCLES - 32'd2) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [4:0] w_dec_sel;
  logic       w_dec_ill;
  logic [1:0] w_dec_cls;
  logic       w_dec_multi;
  logic [3:0] w_dec_load;
  logic       w_in_ready;
  logic       w_accept;

  // Shared funct3 map used by OP (funct7=0) and OP-IMM.
  function automatic logic [4:0] alu_base(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_base = SEL_ADD;
      3'b001:  alu_base = SEL_SLL;
      3'b010:  alu_base = SEL_SLT;
      3'b011:  alu_base = SEL_SLTU;
      3'b100:  alu_base = SEL_XOR;
      3'b101:  alu_base = SEL_SRL;
      3'b110:  alu_base = SEL_OR;
      default: alu_base = SEL_AND;
    endcase
  endfunction

  // Instruction decode: select code, illegal flag, latency class.
  always_comb begin
    w_dec_sel = SEL_NOP;
    w_dec_ill = 1'b1;
    w_dec_cls = CLS_SINGLE;
    case (i_opcode)
      OPC_OP: begin
        if (i_funct7 == 7'b0000000) begin
          w_dec_sel = alu_base(i_funct3);
          w_dec_ill = 1'b0;
        end else if (i_funct7 == 7'b0100000) begin
          if (i_funct3 == 3'b000) begin
            w_dec_sel = SEL_SUB;
            w_dec_ill = 1'b0;
          end else if (i_funct3 == 3'b101) begin
            w_dec_sel = SEL_SRA;
            w_dec_ill = 1'b0;
          end else begin
            w_dec_ill = 1'b1;
          end
        end
`ifdef RV32M_EN
        else if (i_funct7 == 7'b0000001) begin
          // MUL..REMU occupy consecutive codes 11..18 in funct3 order.
          w_dec_sel = 5'd11 + {2'b00, i_funct3};
          w_dec_ill = 1'b0;
          w_dec_cls = i_funct3[2] ? CLS_DIV : CLS_MUL;
        end
`endif
        else begin
          w_dec_ill = 1'b1;
        end
      end
      OPC_OPIMM: begin
        // funct7 only matters for the shift-immediate encodings.
        case (i_funct3)
          3'b001: begin
            if (i_funct7 == 7'b0000000) begin
              w_dec_sel = SEL_SLL;
              w_dec_ill = 1'b0;
            end else begin
              w_dec_ill = 1'b1;
            end
          end
          3'b101: begin
            if (i_funct7 == 7'b0000000) begin
              w_dec_sel = SEL_SRL;
              w_dec_ill = 1'b0;
            end else if (i_funct7 == 7'b0100000) begin
              w_dec_sel = SEL_SRA;
              w_dec_ill = 1'b0;
            end else begin
              w_dec_ill = 1'b1;
            end
          end
          default: begin
            w_dec_sel = alu_base(i_funct3);
            w_dec_ill = 1'b0;
          end
        endcase
      end
      OPC_LUI: begin
        w_dec_sel = SEL_FWD;
        w_dec_ill = 1'b0;
      end
      OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR: begin
        w_dec_sel = SEL_ADD;
        w_dec_ill = 1'b0;
      end
      OPC_BRANCH: begin
        case (i_funct3)
          3'b000, 3'b001: begin w_dec_sel = SEL_SUB;  w_dec_ill = 1'b0; end
          3'b100, 3'b101: begin w_dec_sel = SEL_SLT;  w_dec_ill = 1'b0; end
          3'b110, 3'b111: begin w_dec_sel = SEL_SLTU; w_dec_ill = 1'b0; end
          default:        begin w_dec_sel = SEL_NOP;  w_dec_ill = 1'b1; end
        endcase
      end
      default: begin
        w_dec_sel = SEL_NOP;
        w_dec_ill = 1'b1;
      end
    endcase
  end

  // Latency of the decoded op: whether it needs EXEC, and the counter preload.
  always_comb begin
    w_dec_multi = ((w_dec_cls == CLS_MUL) && (MUL_CYCLES > 32'd1)) ||
                  ((w_dec_cls == CLS_DIV) && (DIV_CYCLES > 32'd1));
    if (w_dec_cls == CLS_MUL) begin
      w_dec_load = MUL_LOAD;
    end else begin
      w_dec_load = DIV_LOAD;
    end
  end

  // Handshake: ready in IDLE, or in DONE while the result is being consumed.
  always_comb begin
    if (i_reset) begin
      w_in_ready = 1'b0;
    end else begin
      w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && i_out_ready);
    end
    w_accept = i_in_valid && w_in_ready;
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_dec_multi ? ST_EXEC : ST_DONE;
        end else if ((r_state == ST_DONE) && i_out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_EXEC: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register.
  always_comb begin
    o_in_ready  = w_in_ready;
    o_out_valid = (r_state == ST_DONE);
`ifdef RV32M_EN
    o_busy      = (r_state == ST_EXEC);
`else
    o_busy      = 1'b0;
`endif
  end

  // Select/illegal capture on accept; held until the next accept.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_select  <= SEL_NOP;
      o_illegal <= 1'b0;
    end else if (w_accept) begin
      o_select  <= w_dec_sel;
      o_illegal <= w_dec_ill;
    end else begin
      o_select  <= o_select;
      o_illegal <= o_illegal;
    end
  end

  // Multi-cycle countdown: loaded on accept, decremented while in EXEC.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= w_dec_multi ? w_dec_load : 4'd0;
    end else if ((r_state == ST_EXEC) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: doc/alu_op_issue.md
ALU_OP_ISSUE -- requirements
Module: alu_op_issue

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 2, meaning cycles from accept to OUT_VALID for MUL-class ops (legal range 1-15).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 4, meaning cycles from accept to OUT_VALID for DIV/REM-class ops (legal range 1-15).
REQ-003 CLK  input  1  single clock, all state updates on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 OPCODE  input  7  instruction bits [6:0].
REQ-006 FUNCT3  input  3  instruction bits [14:12].
REQ-007 FUNCT7  input  7  instruction bits [31:25].
REQ-008 IN_VALID  input  1  upstream presents an instruction.
REQ-009 IN_READY  output  1  block accepts an instruction this cycle.
REQ-010 SELECT  output  5  registered ALU opcode driven into the ALU SELECT port.
REQ-011 OUT_VALID  output  1  SELECT is final and ALU RESULT may be consumed.
REQ-012 OUT_READY  input  1  downstream consumes SELECT/RESULT this cycle.
REQ-013 BUSY  output  1  multi-cycle operation in progress (pipeline stall).
REQ-014 ILLEGAL  output  1  accepted instruction did not decode; valid only with OUT_VALID.

Function
REQ-015 SELECT encoding SHALL be: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLL 00101, SRL 00110, SRA 00111, SLT 01000, SLTU 01001, FWD 01010, MUL 01011, MULH 01100, MULHSU 01101, MULHU 01110, DIV 01111, DIVU 10000, REM 10001, REMU 10010, NOP 11111.
REQ-016 OP (0110011), FUNCT7=0000000 SHALL map FUNCT3 000..111 to ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND; FUNCT7=0100000 with FUNCT3 000/101 SHALL map to SUB/SRA.
REQ-017 OP-IMM (0010011) SHALL map as OP with FUNCT7 ignored, except FUNCT3=001 requires FUNCT7=0000000 (SLL) and FUNCT3=101 requires FUNCT7 0000000 (SRL) or 0100000 (SRA).
REQ-018 LUI SHALL map to FWD; AUIPC, LOAD, STORE, JAL, JALR SHALL map to ADD.
REQ-019 BRANCH (1100011) SHALL map FUNCT3 000/001 to SUB, 100/101 to SLT, 110/111 to SLTU; 010/011 illegal.
REQ-020 Any other encoding SHALL produce SELECT=NOP and ILLEGAL=1 with single-cycle latency.
REQ-021 Accept occurs on a rising edge where IN_VALID and IN_READY are both 1.
REQ-022 FSM states SHALL be IDLE, EXEC, DONE; IDLE->DONE on accept of single-cycle or illegal op; IDLE->EXEC on accept of MUL/DIV-class op with latency >1; EXEC->DONE when the cycle counter expires; DONE->IDLE on OUT_READY without accept; DONE->DONE/EXEC on OUT_READY with simultaneous accept.
REQ-023 OUT_VALID SHALL rise exactly L cycles after the accept edge: L=1 single-cycle, L=MUL_CYCLES for MUL/MULH/MULHSU/MULHU, L=DIV_CYCLES for DIV/DIVU/REM/REMU.
REQ-024 IN_READY SHALL be 1 in IDLE, 1 in DONE when OUT_READY=1, and 0 in EXEC or in DONE with OUT_READY=0.
REQ-025 SELECT SHALL update only on accept and SHALL hold stable through EXEC and DONE until the next accept.
REQ-026 SELECT, ILLEGAL SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-027 BUSY SHALL equal 1 exactly in EXEC.
REQ-028 Back-to-back single-cycle ops with OUT_READY held 1 SHALL sustain one op per cycle.
REQ-029 OUT_READY in IDLE or EXEC SHALL have no effect.

Reset
REQ-030 RESET=1 at a rising edge SHALL force IDLE, SELECT=NOP, OUT_VALID=0, BUSY=0, ILLEGAL=0, counter=0, taking priority over any accept.
REQ-031 RESET asserted in EXEC or DONE SHALL abort the operation with no OUT_VALID pulse.
REQ-032 IN_READY SHALL be 0 while RESET=1 and 1 in the first cycle after RESET deasserts.

Configuration
REQ-033 Macro RV32M_EN defined: OP with FUNCT7=0000001 SHALL map FUNCT3 000..111 to MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU.
REQ-034 RV32M_EN undefined: those encodings SHALL be illegal (NOP, ILLEGAL=1, L=1), EXEC SHALL be unreachable, BUSY SHALL be constant 0.

Verification
REQ-035 Reset then OP ADD (0110011/000/0000000), IN_VALID=1, OUT_READY=1 -> next cycle SELECT=00000, OUT_VALID=1, ILLEGAL=0.
REQ-036 OP SUB then OP-IMM SRAI (0010011/101/0100000) back-to-back, OUT_READY=1 -> SELECT 00001 then 00111 on consecutive cycles, IN_READY never low.
REQ-037 RV32M_EN, DIV (0110011/100/0000001), DIV_CYCLES=4 -> BUSY=1 for 3 cycles, OUT_VALID at cycle 4, SELECT=01111, IN_READY=0 meanwhile; without RV32M_EN -> SELECT=11111, ILLEGAL=1 at cycle 1.
REQ-038 BRANCH BLTU (1100011/110) with OUT_READY=0 for 3 cycles -> SELECT=01001 held, OUT_VALID=1 held, IN_READY=0 until OUT_READY=1.
REQ-039 Opcode 1111111 -> SELECT=11111, ILLEGAL=1, OUT_VALID=1 after 1 cycle.
REQ-040 RESET asserted second cycle of MUL (MUL_CYCLES=2) -> no OUT_VALID, SELECT=11111, IN_READY=1 the cycle after RESET drops.
